// File: rtl/cascade_stage_evaluator_if.sv
// Vote stream and stage-threshold ROM bus between the weak-classifier array,
// the threshold ROM and the cascade stage evaluator.
interface cascade_stage_evaluator_if #(
   parameter int ACC_W = 24
);
   logic             vote_valid;
   logic             vote_ready;
   logic [ACC_W-1:0] vote_value;
   logic             vote_last;
   logic [4:0]       stage_addr;
   logic [ACC_W-1:0] thr_in;

   modport master (
      output vote_valid, vote_value, vote_last, thr_in,
      input  vote_ready, stage_addr
   );

   modport slave (
      input  vote_valid, vote_value, vote_last, thr_in,
      output vote_ready, stage_addr
   );
endinterface

// File: rtl/cascade_stage_evaluator.sv
// Per-window Haar cascade stage engine: sums weak-classifier votes per stage,
// compares against the ROM threshold and walks stages until reject or face.
module cascade_stage_evaluator #(
   parameter int NUM_STAGES  = 22,
   parameter int FIRST_STAGE = 1,
   parameter int ACC_W       = 24
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   cascade_stage_evaluator_if.slave   vbus,
   output logic                       busy,
   output logic                       done,
   output logic                       face,
   output logic [4:0]                 reject_stage
);

   localparam logic [4:0] ADDR_FIRST = 5'(FIRST_STAGE);
   localparam logic [4:0] ADDR_LAST  = 5'(FIRST_STAGE + NUM_STAGES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ACCUM,
      S_CMP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [4:0]       addr_q, addr_d;
   logic             face_q, face_d;
   logic [4:0]       reject_q, reject_d;
   logic [ACC_W:0]   sum;
   logic             ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         addr_q   <= ADDR_FIRST;
         face_q   <= 1'b0;
         reject_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         addr_q   <= addr_d;
         face_q   <= face_d;
         reject_q <= reject_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      addr_d   = addr_q;
      face_d   = face_q;
      reject_d = reject_q;
      ready    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      // One extra carry bit detects overflow so the sum clamps instead of wrapping.
      sum      = {1'b0, acc_q} + {1'b0, vbus.vote_value};

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d    = '0;
               addr_d   = ADDR_FIRST;
               face_d   = 1'b0;
               reject_d = '0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            busy    = 1'b1;
            state_d = S_ACCUM;
         end
         S_ACCUM: begin
            busy  = 1'b1;
            ready = 1'b1;
            if (vbus.vote_valid) begin
               acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
               if (vbus.vote_last) begin
                  state_d = S_CMP;
               end
            end
         end
         S_CMP: begin
            busy = 1'b1;
            if (acc_q >= vbus.thr_in) begin
               if (addr_q == ADDR_LAST) begin
                  face_d   = 1'b1;
                  reject_d = '0;
                  state_d  = S_DONE;
               end else begin
                  addr_d  = addr_q + 5'd1;
                  acc_d   = '0;
                  state_d = S_LOAD;
               end
            end else begin
               face_d   = 1'b0;
               reject_d = addr_q - ADDR_FIRST + 5'd1;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign vbus.vote_ready = ready;
   assign vbus.stage_addr = addr_q;
   assign face            = face_q;
   assign reject_stage    = reject_q;

endmodule
